// File: rtl/col_fetch_sched_pkg.sv
// Shared types and constants for the column fetch scheduler.
// Holds the FSM state encoding and memory word geometry.
package col_fetch_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ISSUE,
    DONE
  } state_t;

  localparam int DEF_MEMORY_WIDTH = 512;
  localparam int BYTES_PER_WORD   = DEF_MEMORY_WIDTH / 8;
  localparam int DEF_FIFO_WORDS   = 512;

  function automatic int bytes_per_word(input int mem_width);
    return mem_width / 8;
  endfunction

endpackage

// File: rtl/col_fetch_sched_credit.sv
// Per-column credit counter for the downstream word buffer.
// Same-cycle return and issue net out; result clamps to [0, FIFO_WORDS].
module col_credit_ctr
  import col_fetch_sched_pkg::*;
#(
  parameter int FIFO_WORDS = DEF_FIFO_WORDS,
  parameter int CW         = $clog2(FIFO_WORDS) + 1,
  parameter int WW         = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic [WW-1:0] dec_words,
  output logic [CW-1:0] credits
);

  localparam int SW = ((CW > WW) ? CW : WW) + 2;

  logic [SW-1:0] avail;
  logic [SW-1:0] take;
  logic [SW-1:0] net;
  logic [CW-1:0] credits_d;

  always_comb begin
    avail = SW'(credits) + SW'(inc);
    take  = dec ? SW'(dec_words) : '0;
    net   = avail - take;
    credits_d = CW'(net);
    if (take > avail)
      credits_d = '0;
    else if (net > SW'(FIFO_WORDS))
      credits_d = CW'(FIFO_WORDS);
  end

  always_ff @(posedge clk) begin
    if (rst)
      credits <= CW'(FIFO_WORDS);
    else
      credits <= credits_d;
  end

endmodule

// File: rtl/col_fetch_sched.sv
// Column-interleaved read command scheduler.
// Issues one command per column per page, gated by downstream credits.
module col_fetch_sched
  import col_fetch_sched_pkg::*;
#(
  parameter int COL_COUNT    = 3,
  parameter int ADDR_WIDTH   = 64,
  parameter int LEN_WIDTH    = 16,
  parameter int MEMORY_WIDTH = 512,
  parameter int FIFO_WORDS   = DEF_FIFO_WORDS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  input  logic [$clog2(COL_COUNT)-1:0] cfg_col,
  input  logic [ADDR_WIDTH-1:0]        cfg_base,
  input  logic [LEN_WIDTH-1:0]         cfg_len,
  input  logic                         start_valid,
  input  logic [15:0]                  start_pages,
  output logic                         start_ready,
  output logic                         cmd_valid,
  output logic [ADDR_WIDTH-1:0]        cmd_addr,
  output logic [LEN_WIDTH-1:0]         cmd_len,
  input  logic                         cmd_ready,
  input  logic                         credit_valid,
  input  logic [$clog2(COL_COUNT)-1:0] credit_col,
  output logic                         busy,
  output logic                         done
);

  localparam int CIW  = $clog2(COL_COUNT);
  localparam int CW   = $clog2(FIFO_WORDS) + 1;
  localparam int WW   = LEN_WIDTH + 1;
  localparam int BPW  = bytes_per_word(MEMORY_WIDTH);
  localparam int CMPW = (CW > WW) ? CW : WW;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] base_q     [COL_COUNT];
  logic [ADDR_WIDTH-1:0] cur_addr_q [COL_COUNT];
  logic [LEN_WIDTH-1:0]  len_q      [COL_COUNT];
  logic [WW-1:0]         words      [COL_COUNT];
  logic [CW-1:0]         credits    [COL_COUNT];

  logic [CIW-1:0] col_q;
  logic [15:0]    page_q;
  logic [15:0]    pages_q;

  logic fire;
  logic last;
  logic credit_ok;
  logic start_go;

  always_comb begin
    for (int c = 0; c < COL_COUNT; c++)
      words[c] = (WW'(len_q[c]) + WW'(BPW - 1)) / WW'(BPW);
  end

  assign fire      = (state_q == ISSUE) && cmd_ready;
  assign last      = (col_q == CIW'(COL_COUNT - 1)) &&
                     (page_q == pages_q - 16'd1);
  assign credit_ok = CMPW'(credits[col_q]) >= CMPW'(words[col_q]);
  assign start_go  = (state_q == IDLE) && start_valid;

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign cmd_valid   = (state_q == ISSUE);
  assign cmd_addr    = cur_addr_q[col_q];
  assign cmd_len     = len_q[col_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start_valid)
          state_d = (start_pages == 16'd0) ? DONE : CHECK;
      CHECK:
        if (credit_ok)
          state_d = ISSUE;
      ISSUE:
        if (cmd_ready)
          state_d = last ? DONE : CHECK;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < COL_COUNT; c++) begin
        base_q[c]     <= '0;
        len_q[c]      <= '0;
        cur_addr_q[c] <= '0;
      end
      col_q   <= '0;
      page_q  <= '0;
      pages_q <= '0;
    end else begin
      if ((state_q == IDLE) && cfg_valid &&
          (32'(cfg_col) < COL_COUNT)) begin
        base_q[cfg_col] <= cfg_base;
        len_q[cfg_col]  <= cfg_len;
      end
      if (start_go && (start_pages != 16'd0)) begin
        pages_q <= start_pages;
        col_q   <= '0;
        page_q  <= '0;
        for (int c = 0; c < COL_COUNT; c++)
          cur_addr_q[c] <= base_q[c];
      end
      if (fire) begin
        cur_addr_q[col_q] <= cur_addr_q[col_q] +
                             ADDR_WIDTH'(len_q[col_q]);
        if (col_q == CIW'(COL_COUNT - 1)) begin
          col_q  <= '0;
          page_q <= page_q + 16'd1;
        end else begin
          col_q <= col_q + CIW'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < COL_COUNT; c++) begin : g_cred
    col_credit_ctr #(
      .FIFO_WORDS(FIFO_WORDS),
      .CW        (CW),
      .WW        (WW)
    ) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .inc      (credit_valid && (credit_col == CIW'(c))),
      .dec      (fire && (col_q == CIW'(c))),
      .dec_words(words[c]),
      .credits  (credits[c])
    );
  end

endmodule
